branch_predictor_2bit: RTL and testbench
========================================

# branch_predictor_2bit

Parametrised, tagged branch predictor for the five-stage RISC-V pipeline. It pairs a table of 2-bit saturating direction counters with a tagged branch target buffer. The IF/ID stage reads a direction and target prediction. The EX/MEM stage writes resolved outcomes back and gets a registered-state checkout with a mispredict flag. Saturating performance counters track the number of resolved branches and mispredictions.

## Interface
- DATA_WIDTH, 32, PC and target width
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_WIDTH, 8, tag bits; IDX_W+2+TAG_WIDTH ≤ DATA_WIDTH
- CTR_INIT, 2'b01, counter value after reset/flush
- CNT_WIDTH, 16, performance counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- if_id_opcode  in  7  opcode of instruction in IF/ID
- if_pc  in  DATA_WIDTH  PC of that instruction
- ex_mem_opcode  in  7  opcode in EX/MEM
- ex_mem_pc  in  DATA_WIDTH  PC in EX/MEM
- ex_mem_branch_taken  in  1  resolved direction
- ex_mem_branch_target  in  DATA_WIDTH  resolved target
- i_flush_tbl  in  1  synchronous clear of all valid bits and counters
- prediction  out  1  predict taken for if_pc
- branch_target  out  DATA_WIDTH  predicted target for if_pc
- btb_hit  out  1  if_pc hits a valid, tag-matching entry
- prediction_checkout_ex_mem  out  1  prediction the table gives for ex_mem_pc
- mispredict  out  1  EX/MEM branch was mispredicted
- branch_cnt  out  CNT_WIDTH  resolved B-type count, saturating
- mispredict_cnt  out  CNT_WIDTH  mispredict count, saturating

## Operation
- B_TYPE = 7'b1100011. Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+1+TAG_WIDTH:IDX_W+2].
- Entry fields: valid, tag[TAG_WIDTH], ctr[2], target[DATA_WIDTH].
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when ctr[1] = 1.
- IF read (combinational) for if_pc:
  - hit = valid & tag match.
  - btb_hit = (if_id_opcode==B_TYPE) & hit.
  - prediction = btb_hit & ctr[1].
  - branch_target = btb_hit ? target : 0.
- Checkout (combinational, pre-update state) for ex_mem_pc, using the same rule:
  - prediction_checkout_ex_mem = (ex_mem_opcode==B_TYPE) & hit & ctr[1].
- mispredict = (ex_mem_opcode==B_TYPE) & ((checkout != ex_mem_branch_taken) | (checkout & ex_mem_branch_taken & stored target != ex_mem_branch_target)).
- Update on a clock edge when ex_mem_opcode==B_TYPE and i_flush_tbl=0:
  - Hit, taken: ctr = min(ctr+1, 3); target <= ex_mem_branch_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch): allocate. valid <= 1, tag <= new tag, target <= ex_mem_branch_target. ctr <= taken ? 2'b10 : 2'b01.
- Performance counters, same edge:
  - branch_cnt += 1 per B-type in EX/MEM.
  - mispredict_cnt += 1 when mispredict is high.
  - Both hold at all-ones.
- i_flush_tbl: all valid <= 0 and all ctr <= CTR_INIT. Tags and targets are untouched. Performance counters are not cleared. Flush wins over a same-cycle update, but the counters still count that cycle's branch.

## Timing
- Reset (asynchronous): all valid=0, ctr=CTR_INIT, tag=0, target=0, branch_cnt=0, mispredict_cnt=0. Hence prediction=0, branch_target=0, btb_hit=0, checkout=0 and mispredict=0 (mispredict rises only if a B-type sits in EX/MEM with taken=1).
- Reads and checkout: zero latency. Updates are visible on the cycle after the edge.
- Same index read in IF and written from EX/MEM in one cycle: IF sees the old entry (no bypass).
- Reset deasserted mid-operation: the table is empty and the next branch allocates. Reset asserted mid-update: the update is lost.
- Aliasing (same index, different tag): the entry is replaced and the old branch is forgotten.

## Test plan
- Reset, then IF B-type at if_pc=0x10 -> prediction=0, btb_hit=0, branch_target=0.
- EX/MEM B-type pc=0x10, taken, target 0x40 -> mispredict=1 that cycle. Next cycle, IF pc=0x10 -> btb_hit=1, prediction=1, target=0x40, branch_cnt=1, mispredict_cnt=1.
- Same branch not-taken once (ctr 10→01) -> prediction=0. Taken ×3 -> ctr 11 (saturates). One not-taken -> still predicts taken.
- ENTRIES=8, TAG_WIDTH=8: allocate pc=0x10 (idx4, tag0), then resolve pc=0x30 (idx4, tag1) taken to 0x80 -> pc=0x10 misses, pc=0x30 hits with target 0x80.
- Update and i_flush_tbl in the same cycle -> table empty next cycle, branch_cnt still incremented.
- Force 2^CNT_WIDTH+3 mispredicts (CNT_WIDTH=4) -> both counters hold at 0xF.

Source files
------------

// File: rtl/branch_predictor_2bit.sv
// Tagged 2-bit direction predictor with branch target buffer.
// The IF/ID side reads a direction and target for if_pc with no latency.
// The EX/MEM side gets a checkout of the pre-update entry for ex_mem_pc,
// a mispredict flag, and writes the resolved outcome back on the clock edge.
// Saturating counters track resolved branches and mispredictions.
module branch_predictor_2bit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ENTRIES    = 16,
  parameter int          TAG_WIDTH  = 8,
  parameter logic [1:0]  CTR_INIT   = 2'b01,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            if_id_opcode,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic [6:0]            ex_mem_opcode,
  input  logic [DATA_WIDTH-1:0] ex_mem_pc,
  input  logic                  ex_mem_branch_taken,
  input  logic [DATA_WIDTH-1:0] ex_mem_branch_target,
  input  logic                  i_flush_tbl,
  output logic                  prediction,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic                  btb_hit,
  output logic                  prediction_checkout_ex_mem,
  output logic                  mispredict,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam int         IDX_W  = $clog2(ENTRIES);
  localparam logic [6:0] B_TYPE = 7'b1100011;

  // Table storage, one slot per index.
  logic                  valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];

  // IF-side lookup.
  logic [IDX_W-1:0]     if_idx;
  logic [TAG_WIDTH-1:0] if_tag;
  logic                 if_is_b;
  logic                 if_hit;

  // EX/MEM-side lookup.
  logic [IDX_W-1:0]     ex_idx;
  logic [TAG_WIDTH-1:0] ex_tag;
  logic                 ex_is_b;
  logic                 ex_hit;
  logic                 ex_checkout;
  logic                 ex_target_diff;

  // Write-back values for the EX/MEM entry.
  logic [1:0]           ctr_nxt;
  logic                 target_wr;

  // Only the index and tag slices of each PC feed the table; the rest of the
  // address is folded here so it is visibly consumed.
  logic                 unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_mem_pc};

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+1+TAG_WIDTH:IDX_W+2];
  assign if_is_b = (if_id_opcode == B_TYPE);
  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign ex_idx  = ex_mem_pc[IDX_W+1:2];
  assign ex_tag  = ex_mem_pc[IDX_W+1+TAG_WIDTH:IDX_W+2];
  assign ex_is_b = (ex_mem_opcode == B_TYPE);
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // IF prediction: only a B-type that hits a live entry gets a prediction.
  assign btb_hit       = if_is_b && if_hit;
  assign prediction    = btb_hit && ctr_q[if_idx][1];
  assign branch_target = btb_hit ? target_q[if_idx] : '0;

  // Checkout uses the entry as it stands before this cycle's write-back.
  assign ex_checkout                = ex_is_b && ex_hit && ctr_q[ex_idx][1];
  assign prediction_checkout_ex_mem = ex_checkout;
  assign ex_target_diff             = (target_q[ex_idx] != ex_mem_branch_target);

  // A predicted-taken branch that goes to a different target also counts as
  // a mispredict, since fetch would have been redirected to the wrong place.
  assign mispredict = ex_is_b &&
                      ((ex_checkout != ex_mem_branch_taken) ||
                       (ex_checkout && ex_mem_branch_taken && ex_target_diff));

  // Next counter value and target-write enable for the resolved entry.
  always_comb begin
    ctr_nxt   = ctr_q[ex_idx];
    target_wr = 1'b0;
    if (ex_hit) begin
      if (ex_mem_branch_taken) begin
        ctr_nxt   = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        target_wr = 1'b1;
      end else begin
        ctr_nxt   = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
      end
    end else begin
      // Allocation replaces whatever lived at this index, aliases included.
      ctr_nxt   = ex_mem_branch_taken ? 2'b10 : 2'b01;
      target_wr = 1'b1;
    end
  end

  // Table state: flush clears valid/ctr and beats a same-cycle write-back;
  // tags and targets are left alone by a flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_INIT;
        target_q[i] <= '0;
      end
    end else if (i_flush_tbl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (ex_is_b) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      ctr_q[ex_idx]   <= ctr_nxt;
      if (target_wr) begin
        target_q[ex_idx] <= ex_mem_branch_target;
      end
    end
  end

  // Saturating performance counters; they count even in a flush cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_is_b && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (mispredict && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Directed bench for branch_predictor_2bit: a default-size instance and a
// small one (8 entries, 4-bit counters) driven with the same stimulus.
module tb_branch_predictor_2bit;

  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] NB = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic [6:0]  if_op;
  logic [31:0] if_pc;
  logic [6:0]  ex_op;
  logic [31:0] ex_pc;
  logic        taken;
  logic [31:0] ex_tgt;
  logic        flush;

  logic        pred, hit, chk, misp;
  logic [31:0] tgt;
  logic [15:0] bcnt, mcnt;

  logic        s_pred, s_hit, s_chk, s_misp;
  logic [31:0] s_tgt;
  logic [3:0]  s_bcnt, s_mcnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor_2bit dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .if_id_opcode(if_op), .if_pc(if_pc),
    .ex_mem_opcode(ex_op), .ex_mem_pc(ex_pc),
    .ex_mem_branch_taken(taken), .ex_mem_branch_target(ex_tgt),
    .i_flush_tbl(flush),
    .prediction(pred), .branch_target(tgt), .btb_hit(hit),
    .prediction_checkout_ex_mem(chk), .mispredict(misp),
    .branch_cnt(bcnt), .mispredict_cnt(mcnt)
  );

  branch_predictor_2bit #(.ENTRIES(8), .TAG_WIDTH(8), .CNT_WIDTH(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .if_id_opcode(if_op), .if_pc(if_pc),
    .ex_mem_opcode(ex_op), .ex_mem_pc(ex_pc),
    .ex_mem_branch_taken(taken), .ex_mem_branch_target(ex_tgt),
    .i_flush_tbl(flush),
    .prediction(s_pred), .branch_target(s_tgt), .btb_hit(s_hit),
    .prediction_checkout_ex_mem(s_chk), .mispredict(s_misp),
    .branch_cnt(s_bcnt), .mispredict_cnt(s_mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  if_op;
    logic [31:0] if_pc;
    logic [6:0]  ex_op;
    logic [31:0] ex_pc;
    logic        taken;
    logic [31:0] tgt;
    logic        flush;
    logic        e_pred;
    logic [31:0] e_tgt;
    logic        e_hit;
    logic        e_chk;
    logic        e_misp;
    int          e_bc;
    int          e_mc;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic [6:0] a_if_op, logic [31:0] a_if_pc,
                              logic [6:0] a_ex_op, logic [31:0] a_ex_pc,
                              logic a_taken, logic [31:0] a_tgt, logic a_flush,
                              logic a_pred, logic [31:0] a_etgt, logic a_hit,
                              logic a_chk, logic a_misp, int a_bc, int a_mc);
    vec_t v;
    v.if_op = a_if_op; v.if_pc = a_if_pc; v.ex_op = a_ex_op; v.ex_pc = a_ex_pc;
    v.taken = a_taken; v.tgt = a_tgt; v.flush = a_flush;
    v.e_pred = a_pred; v.e_tgt = a_etgt; v.e_hit = a_hit; v.e_chk = a_chk;
    v.e_misp = a_misp; v.e_bc = a_bc; v.e_mc = a_mc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] a_if_op, input logic [31:0] a_if_pc,
                       input logic [6:0] a_ex_op, input logic [31:0] a_ex_pc,
                       input logic a_taken, input logic [31:0] a_tgt,
                       input logic a_flush);
    if_op = a_if_op; if_pc = a_if_pc; ex_op = a_ex_op; ex_pc = a_ex_pc;
    taken = a_taken; ex_tgt = a_tgt; flush = a_flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // IF/EX columns | expected pred, tgt, hit, checkout, mispredict, bcnt, mcnt
    vecs[0]  = mk(B, 32'h10, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(B, 32'h10, B,  32'h10, 1, 32'h40,  0, 0, 32'h0,  0, 0, 1, 0, 0);
    vecs[2]  = mk(B, 32'h10, NB, 32'h0,  0, 32'h0,   0, 1, 32'h40, 1, 0, 0, 1, 1);
    vecs[3]  = mk(B, 32'h10, B,  32'h10, 0, 32'h14,  0, 1, 32'h40, 1, 1, 1, 1, 1);
    vecs[4]  = mk(B, 32'h10, NB, 32'h0,  0, 32'h0,   0, 0, 32'h40, 1, 0, 0, 2, 2);
    vecs[5]  = mk(B, 32'h10, B,  32'h10, 1, 32'h40,  0, 0, 32'h40, 1, 0, 1, 2, 2);
    vecs[6]  = mk(B, 32'h10, B,  32'h10, 1, 32'h40,  0, 1, 32'h40, 1, 1, 0, 3, 3);
    vecs[7]  = mk(B, 32'h10, B,  32'h10, 1, 32'h40,  0, 1, 32'h40, 1, 1, 0, 4, 3);
    vecs[8]  = mk(B, 32'h10, B,  32'h10, 0, 32'h14,  0, 1, 32'h40, 1, 1, 1, 5, 3);
    vecs[9]  = mk(B, 32'h10, NB, 32'h0,  0, 32'h0,   0, 1, 32'h40, 1, 0, 0, 6, 4);
    vecs[10] = mk(B, 32'h10, B,  32'h10, 1, 32'h80,  0, 1, 32'h40, 1, 1, 1, 6, 4);
    vecs[11] = mk(NB,32'h10, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 7, 5);
    vecs[12] = mk(B, 32'h10, NB, 32'h10, 1, 32'h80,  0, 1, 32'h80, 1, 0, 0, 7, 5);
    vecs[13] = mk(B, 32'h50, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 7, 5);
    vecs[14] = mk(B, 32'h10, B,  32'h50, 0, 32'h54,  0, 1, 32'h80, 1, 0, 0, 7, 5);
    vecs[15] = mk(B, 32'h10, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 8, 5);
    vecs[16] = mk(B, 32'h50, NB, 32'h0,  0, 32'h0,   0, 0, 32'h54, 1, 0, 0, 8, 5);
    vecs[17] = mk(B, 32'h50, B,  32'h20, 1, 32'h100, 1, 0, 32'h54, 1, 0, 1, 8, 5);
    vecs[18] = mk(B, 32'h50, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 9, 6);
    vecs[19] = mk(B, 32'h20, NB, 32'h0,  0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 9, 6);
    vecs[20] = mk(B, 32'h50, B,  32'h50, 0, 32'h58,  0, 0, 32'h0,  0, 0, 0, 9, 6);
    vecs[21] = mk(B, 32'h50, NB, 32'h0,  0, 32'h0,   0, 0, 32'h58, 1, 0, 0, 10, 6);

    // Reset state.
    rst_n = 1'b0;
    drive(B, 32'h10, B, 32'h10, 0, 32'h40, 0);
    #12;
    check("rst pred", pred, 0);
    check("rst btb_hit", hit, 0);
    check("rst target", tgt, 0);
    check("rst checkout", chk, 0);
    check("rst mispredict nt", misp, 0);
    check("rst branch_cnt", bcnt, 0);
    check("rst mispredict_cnt", mcnt, 0);
    taken = 1'b1;
    #1;
    check("rst mispredict taken", misp, 1);
    drive(NB, 32'h0, NB, 32'h0, 0, 32'h0, 0);
    #9;
    rst_n = 1'b1;
    step();

    // Table-driven sequence: counter walk, target change, aliasing, flush.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].if_op, vecs[i].if_pc, vecs[i].ex_op, vecs[i].ex_pc,
            vecs[i].taken, vecs[i].tgt, vecs[i].flush);
      #2;
      check($sformatf("v%0d prediction", i), pred, vecs[i].e_pred);
      check($sformatf("v%0d branch_target", i), tgt, vecs[i].e_tgt);
      check($sformatf("v%0d btb_hit", i), hit, vecs[i].e_hit);
      check($sformatf("v%0d checkout", i), chk, vecs[i].e_chk);
      check($sformatf("v%0d mispredict", i), misp, vecs[i].e_misp);
      check($sformatf("v%0d branch_cnt", i), bcnt, 64'(vecs[i].e_bc));
      check($sformatf("v%0d mispredict_cnt", i), mcnt, 64'(vecs[i].e_mc));
      check($sformatf("v%0d small branch_cnt", i), s_bcnt, 64'(vecs[i].e_bc));
      check($sformatf("v%0d small mispredict_cnt", i), s_mcnt, 64'(vecs[i].e_mc));
      step();
    end

    // Aliasing on the 8-entry instance: 0x10 and 0x30 share index 4.
    drive(NB, 32'h0, NB, 32'h0, 0, 32'h0, 1);
    step();
    drive(NB, 32'h0, B, 32'h10, 1, 32'h40, 0);
    #1;
    check("alias alloc mispredict", s_misp, 1);
    step();
    drive(NB, 32'h0, B, 32'h30, 1, 32'h80, 0);
    #1;
    check("alias replace checkout", s_chk, 0);
    step();
    drive(B, 32'h10, NB, 32'h0, 0, 32'h0, 0);
    #1;
    check("alias old pc small btb_hit", s_hit, 0);
    check("alias old pc large btb_hit", hit, 1);
    check("alias old pc large target", tgt, 32'h40);
    drive(B, 32'h30, NB, 32'h0, 0, 32'h0, 0);
    #1;
    check("alias new pc small btb_hit", s_hit, 1);
    check("alias new pc small prediction", s_pred, 1);
    check("alias new pc small target", s_tgt, 32'h80);
    check("alias branch_cnt", bcnt, 12);
    check("alias mispredict_cnt", mcnt, 8);

    // Saturation: every resolution below mispredicts (new target each time).
    for (int i = 0; i < 19; i++) begin
      drive(NB, 32'h0, B, 32'h200, 1, 32'h1000 + 32'(i * 4), 0);
      #1;
      check($sformatf("sat%0d mispredict", i), s_misp, 1);
      step();
    end
    drive(NB, 32'h0, NB, 32'h0, 0, 32'h0, 0);
    #1;
    check("sat small branch_cnt", s_bcnt, 4'hF);
    check("sat small mispredict_cnt", s_mcnt, 4'hF);
    check("sat large branch_cnt", bcnt, 31);
    check("sat large mispredict_cnt", mcnt, 27);

    // Reset asserted while an update is pending: the update is lost.
    drive(B, 32'h10, B, 32'h10, 1, 32'h40, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst btb_hit", hit, 0);
    check("midrst branch_cnt", bcnt, 0);
    check("midrst small mispredict_cnt", s_mcnt, 0);
    drive(B, 32'h10, NB, 32'h0, 0, 32'h0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("postrst btb_hit", hit, 0);
    drive(B, 32'h10, B, 32'h10, 1, 32'h40, 0);
    #1;
    check("postrst alloc mispredict", misp, 1);
    step();
    drive(B, 32'h10, NB, 32'h0, 0, 32'h0, 0);
    #1;
    check("postrst btb_hit after alloc", hit, 1);
    check("postrst prediction", pred, 1);
    check("postrst target", tgt, 32'h40);
    check("postrst branch_cnt", bcnt, 1);
    check("postrst mispredict_cnt", mcnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
